// File: rtl/nios_mult_pkg.sv
// Shared types and constants for the limb-decomposed pipelined multiplier.
package nios_mult_pkg;

  localparam int LIMB_W = 16;

  typedef logic [2*LIMB_W-1:0] limb_prod_t;

  typedef struct packed {
    logic signed1;
    logic signed2;
  } mode_t;

  function automatic int limb_count(input int data_w);
    return data_w / LIMB_W;
  endfunction

endpackage

// File: rtl/nios_mult_limb.sv
// One registered LIMB_W x LIMB_W unsigned multiplier cell with clock enable,
// shaped so synthesis maps it onto a single DSP multiplier with output register.
module nios_mult_limb
  import nios_mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  output limb_prod_t        p
);

  limb_prod_t prod_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_reg <= '0;
    end else if (en) begin
      prod_reg <= limb_prod_t'(a) * limb_prod_t'(b);
    end
  end

  assign p = prod_reg;

endmodule

// File: rtl/nios_mult_pipe.sv
// Three-stage pipelined DATA_W x DATA_W multiplier with per-operand signedness,
// valid/ready handshake with global stall, and flush of in-flight operations.
module nios_mult_pipe
  import nios_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_src1,
  input  logic [DATA_W-1:0]   in_src2,
  input  logic                in_signed1,
  input  logic                in_signed2,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_prod,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  localparam int N   = limb_count(DATA_W);
  localparam int P_W = 2 * DATA_W;

  logic adv;
  logic step;

  logic v1_reg, v2_reg, v3_reg;

  logic [DATA_W-1:0] src1_reg, src2_reg;
  mode_t             mode_reg;
  logic [TAG_W-1:0]  tag1_reg;

  limb_prod_t        pp [N*N];
  logic [DATA_W-1:0] corr1_reg, corr2_reg;
  logic [DATA_W-1:0] corr1_next, corr2_next;
  logic [TAG_W-1:0]  tag2_reg;

  logic [P_W-1:0]    prod_reg, prod_next;
  logic [TAG_W-1:0]  tag3_reg;

  // Whole pipe moves as one; flush blocks both acceptance and datapath updates.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~flush;
  assign step     = in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else if (flush) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else if (adv) begin
      v1_reg <= in_valid;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src1_reg <= '0;
      src2_reg <= '0;
      mode_reg <= '0;
      tag1_reg <= '0;
    end else if (step) begin
      src1_reg <= in_src1;
      src2_reg <= in_src2;
      mode_reg <= '{signed1: in_signed1, signed2: in_signed2};
      tag1_reg <= in_tag;
    end
  end

  // Signed operands are treated as unsigned, then their MSB weight is removed.
  assign corr1_next = (mode_reg.signed1 && src1_reg[DATA_W-1]) ? src2_reg : '0;
  assign corr2_next = (mode_reg.signed2 && src2_reg[DATA_W-1]) ? src1_reg : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      nios_mult_limb u_limb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (step),
        .a       (src1_reg[gi*LIMB_W +: LIMB_W]),
        .b       (src2_reg[gj*LIMB_W +: LIMB_W]),
        .p       (pp[gi*N+gj])
      );
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr1_reg <= '0;
      corr2_reg <= '0;
      tag2_reg  <= '0;
    end else if (step) begin
      corr1_reg <= corr1_next;
      corr2_reg <= corr2_next;
      tag2_reg  <= tag1_reg;
    end
  end

  always_comb begin
    prod_next = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod_next = prod_next + (P_W'(pp[i*N+j]) << (LIMB_W * (i + j)));
      end
    end
    prod_next = prod_next - {corr1_reg, {DATA_W{1'b0}}} - {corr2_reg, {DATA_W{1'b0}}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_reg <= '0;
      tag3_reg <= '0;
    end else if (step) begin
      prod_reg <= prod_next;
      tag3_reg <= tag2_reg;
    end
  end

  assign out_valid = v3_reg;
  assign out_prod  = prod_reg;
  assign out_tag   = tag3_reg;
  assign busy      = v1_reg | v2_reg | v3_reg;

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Directed bench for nios_mult_pipe: a 32-bit and a 64-bit instance sharing clock and reset.
module tb_nios_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic flush;

  logic        iv, ir, sg1, sg2, ov, ordy, bsy;
  logic [31:0] s1, s2;
  logic [3:0]  tag, otag;
  logic [63:0] prod;

  logic         iv64, ir64, ov64, ordy64, bsy64;
  logic [63:0]  a64, b64;
  logic [3:0]   tag64, otag64;
  logic [127:0] prod64;

  int checks = 0;
  int errors = 0;

  nios_mult_pipe #(.DATA_W(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(ir),
    .in_src1(s1), .in_src2(s2), .in_signed1(sg1), .in_signed2(sg2),
    .in_tag(tag), .flush(flush), .out_valid(ov), .out_ready(ordy),
    .out_prod(prod), .out_tag(otag), .busy(bsy)
  );

  nios_mult_pipe #(.DATA_W(64), .TAG_W(4)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv64), .in_ready(ir64),
    .in_src1(a64), .in_src2(b64), .in_signed1(1'b0), .in_signed2(1'b0),
    .in_tag(tag64), .flush(flush), .out_valid(ov64), .out_ready(ordy64),
    .out_prod(prod64), .out_tag(otag64), .busy(bsy64)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op, check 3-cycle latency, result, tag and consumption.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic g1, input logic g2, input logic [3:0] t,
                       input logic [63:0] exp);
    iv = 1'b1; s1 = a; s2 = b; sg1 = g1; sg2 = g2; tag = t; ordy = 1'b1;
    #1;
    check({name, "/in_ready"}, ir, 1'b1);
    tick;
    iv = 1'b0;
    check({name, "/lat1"}, ov, 1'b0);
    tick;
    check({name, "/lat2"}, ov, 1'b0);
    tick;
    check({name, "/valid"}, ov, 1'b1);
    check({name, "/prod"}, prod, exp);
    check({name, "/tag"}, otag, t);
    tick;
    check({name, "/drained"}, ov, 1'b0);
    $display("op %s: a=%h b=%h s=%b%b tag=%0d prod=%h", name, a, b, g1, g2, t, exp);
  endtask

  initial begin
    int nin, nout, gaps, leaked;
    reset_n = 1'b0; flush = 1'b0;
    iv = 1'b0; s1 = '0; s2 = '0; sg1 = 1'b0; sg2 = 1'b0; tag = '0; ordy = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; tag64 = '0; ordy64 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", ov, 1'b0);
    check("rst_busy", bsy, 1'b0);
    check("rst_prod", prod, 64'h0);
    check("rst_tag", otag, 4'h0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", ir, 1'b1);
    tick;

    do_op("uu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd3, 64'hFFFFFFFE00000001);
    do_op("ss_m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd5, 64'h0000000000000001);
    do_op("ss_min", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 4'd7, 64'h4000000000000000);
    do_op("su_m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd9, 64'hFFFFFFFF00000001);
    do_op("us_m2",  32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b1, 4'd11, 64'hFFFFFFFFFFFFFFFC);
    do_op("ss_m3",  32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 4'd12, 64'hFFFFFFFFFFFFFFF1);

    // Backpressure: six ops, out_ready low during loop cycles 4..8.
    nin = 0; nout = 0; gaps = 0;
    sg1 = 1'b0; sg2 = 1'b0;
    for (int cyc = 0; cyc < 60 && nout < 6; cyc++) begin
      ordy = !(cyc >= 4 && cyc <= 8);
      iv = (nin < 6);
      s1 = nin + 1; s2 = nin + 3; tag = nin[3:0];
      #1;
      if (ov) begin
        check("bp_tag", otag, nout);
        check("bp_prod", prod, (nout + 1) * (nout + 3));
        if (!ordy) check("bp_in_ready", ir, 1'b0);
        else begin
          $display("bp out: cycle=%0d tag=%0d prod=%0d", cyc, otag, prod);
          nout++;
        end
      end else if (cyc >= 9 && nout < 6) begin
        gaps++;
      end
      if (iv && ir) nin++;
      @(posedge clk);
      #1;
    end
    iv = 1'b0; ordy = 1'b1;
    check("bp_count", nout, 6);
    check("bp_accepted", nin, 6);
    check("bp_gaps", gaps, 0);
    tick;
    check("bp_idle", bsy, 1'b0);

    // Flush with work in flight and a new op presented in the same cycle.
    iv = 1'b1; s1 = 32'd3; s2 = 32'd5; tag = 4'd6;
    tick;
    tag = 4'd7;
    tick;
    tag = 4'd8; flush = 1'b1;
    #1;
    check("fl_in_ready", ir, 1'b0);
    tick;
    flush = 1'b0; iv = 1'b0;
    check("fl_busy", bsy, 1'b0);
    leaked = 0;
    for (int k = 0; k < 5; k++) begin
      if (ov) leaked++;
      tick;
    end
    check("fl_no_output", leaked, 0);
    $display("flush: busy=%b leaked=%0d", bsy, leaked);
    do_op("post_flush", 32'd3, 32'd5, 1'b0, 1'b0, 4'd9, 64'd15);

    // 64-bit rerun in parallel with a stalled 32-bit result, then async reset.
    iv = 1'b1; s1 = 32'hFFFFFFFF; s2 = 32'hFFFFFFFF; sg1 = 1'b0; sg2 = 1'b0; tag = 4'hA; ordy = 1'b0;
    iv64 = 1'b1; a64 = 64'hFFFFFFFFFFFFFFFF; b64 = 64'hFFFFFFFFFFFFFFFF; tag64 = 4'h3; ordy64 = 1'b0;
    tick;
    iv = 1'b0; iv64 = 1'b0;
    tick;
    tick;
    check("w64_valid", ov64, 1'b1);
    check("w64_prod", prod64, 128'hFFFFFFFFFFFFFFFE0000000000000001);
    check("w64_tag", otag64, 4'h3);
    check("stall_valid", ov, 1'b1);
    tick;
    check("stall_prod", prod, 64'hFFFFFFFE00000001);
    check("stall_tag", otag, 4'hA);
    check("stall_in_ready", ir, 1'b0);
    $display("w64: prod=%h tag=%0d", prod64, otag64);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", ov, 1'b0);
    check("arst_prod", prod, 64'h0);
    check("arst_tag", otag, 4'h0);
    check("arst_busy", bsy, 1'b0);
    check("arst_valid64", ov64, 1'b0);
    check("arst_prod64", prod64, 128'h0);
    check("arst_tag64", otag64, 4'h0);
    tick;
    reset_n = 1'b1;
    ordy = 1'b1; ordy64 = 1'b1;
    #1;
    check("arst_in_ready", ir, 1'b1);
    tick;
    check("arst_no_output", ov, 1'b0);
    do_op("after_rst", 32'h0000FFFF, 32'h00010001, 1'b0, 1'b0, 4'd1, 64'h00000000FFFFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
